// File: rtl/uart8_receiver.sv
// 8N1 UART receiver on an OVERSAMPLE x baud clock with a done strobe and framing-error flag.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 3-sample majority around its centre.
module uart8_receiver #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] out
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  localparam logic [2:0] RESET     = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] START_BIT = 3'd2;
  localparam logic [2:0] DATA_BITS = 3'd3;
  localparam logic [2:0] STOP_BIT  = 3'd4;

  logic          sync1_q, in_sync_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    out_q, out_d;
  logic          bit_dec;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Two older samples; together with in_sync_q they form the 3-sample window.
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '1;
    else        hist_q <= {hist_q[0], in_sync_q};
  end

  always_comb begin
    bit_dec = (in_sync_q & hist_q[0]) | (in_sync_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
  end
`else
  always_comb begin
    bit_dec = in_sync_q;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    out_d     = out_q;
    case (state_q)
      RESET: begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (en && in_sync_q) state_d = IDLE;
      end
      IDLE: begin
        if (!in_sync_q) begin
          cnt_d   = '0;
          state_d = START_BIT;
        end
      end
      START_BIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_M1) begin
          if (bit_dec) begin
            state_d = IDLE;
          end else begin
            busy_d    = 1'b1;
            err_d     = 1'b0;
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = DATA_BITS;
          end
        end
      end
      DATA_BITS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FULL_M1) begin
          shift_d[bit_idx_q] = bit_dec;
          cnt_d              = '0;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP_BIT;
        end
      end
      STOP_BIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FULL_M1) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          if (bit_dec) begin
            out_d   = shift_q;
            err_d   = 1'b0;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = RESET;
          end
        end
      end
      default: state_d = RESET;
    endcase
    // Disable wins over any decision taken this cycle; the last result is kept.
    if (!en) begin
      state_d = RESET;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
      out_d   = out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      in_sync_q <= 1'b1;
      state_q   <= RESET;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      out_q     <= '0;
    end else begin
      sync1_q   <= in;
      in_sync_q <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      out_q     <= out_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign out  = out_q;

endmodule

// File: tb/tb_uart8_receiver.sv
// Directed bench for uart8_receiver: frames, back-to-back, glitch, framing error, abort, vote.
module tb_uart8_receiver;

  logic       clk = 1'b0;
  logic       rst_n, en, rx;
  logic       busy, done, err;
  logic [7:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart8_receiver #(.OVERSAMPLE(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .in   (rx),
    .busy (busy),
    .done (done),
    .err  (err),
    .out  (out)
  );

  int         cyc = 0;
  int         done_cnt = 0;
  int         last_done_cyc = 0;
  int         busy_rise_cyc = 0;
  int         busy_cycles = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] done_out = '0;
  logic       done_err = 1'b0;
  int         start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
      done_out      = out;
      done_err      = err;
    end
    if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise_cyc = cyc;
    if (busy === 1'b1) busy_cycles = busy_cycles + 1;
    busy_prev = busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 160-cycle frame; optional single-cycle glitch, en-low cycle and reset pulse by index.
  task automatic send_frame(input logic [7:0] data, input logic stop_v,
                            input int glitch_idx, input int en_idx, input int rst_idx);
    start_cyc = cyc;
    for (int i = 0; i < 160; i++) begin
      int   b;
      logic v;
      b = i / 16;
      if (b == 0)      v = 1'b0;
      else if (b <= 8) v = data[b-1];
      else             v = stop_v;
      if (i == glitch_idx) v = ~v;
      rx = v;
      en = (i != en_idx);
      if (rst_idx >= 0 && i == rst_idx) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_out",  32'(out),  32'h00);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_done", 32'(done), 32'h0);
        check("rst_mid_err",  32'(err),  32'h0);
      end
      if (rst_idx >= 0 && i == rst_idx + 2) rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  int d0, b0, t0;

  initial begin
    rx    = 1'b1;
    en    = 1'b0;
    rst_n = 1'b0;
    #12;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_err",  32'(err),  32'h0);
    check("reset_out",  32'(out),  32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    idle(5);

    // Normal frame 0xA5
    d0 = done_cnt; b0 = busy_cycles;
    send_frame(8'hA5, 1'b1, -1, -1, -1);
    idle(4); #2;
    check("a5_done_count", 32'(done_cnt - d0), 32'd1);
    check("a5_done_time",  32'(last_done_cyc - start_cyc), 32'd155);
    check("a5_busy_rise",  32'(busy_rise_cyc - start_cyc), 32'd11);
    check("a5_busy_len",   32'(busy_cycles - b0), 32'd144);
    check("a5_out",        32'(out), 32'hA5);
    check("a5_err",        32'(err), 32'h0);
    check("a5_busy_after", 32'(busy), 32'h0);

    // Back-to-back frames
    d0 = done_cnt;
    send_frame(8'h00, 1'b1, -1, -1, -1);
    check("b2b_out0", 32'(out), 32'h00);
    t0 = last_done_cyc;
    send_frame(8'hFF, 1'b1, -1, -1, -1);
    check("b2b_out1", 32'(out), 32'hFF);
    check("b2b_gap1", 32'(last_done_cyc - t0), 32'd160);
    t0 = last_done_cyc;
    send_frame(8'h3C, 1'b1, -1, -1, -1);
    check("b2b_out2", 32'(out), 32'h3C);
    check("b2b_gap2", 32'(last_done_cyc - t0), 32'd160);
    check("b2b_count", 32'(done_cnt - d0), 32'd3);
    idle(4);

    // Start-bit glitch
    d0 = done_cnt; b0 = busy_cycles;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40); #2;
    check("glitch_done", 32'(done_cnt - d0), 32'd0);
    check("glitch_busy", 32'(busy_cycles - b0), 32'd0);
    send_frame(8'h5A, 1'b1, -1, -1, -1);
    idle(4); #2;
    check("after_glitch_out",  32'(out), 32'h5A);
    check("after_glitch_err",  32'(err), 32'h0);
    check("after_glitch_done", 32'(done_cnt - d0), 32'd1);

    // Framing error, line held low afterwards
    d0 = done_cnt;
    send_frame(8'h3C, 1'b0, -1, -1, -1);
    b0 = busy_cycles;
    rx = 1'b0;
    idle(40); #2;
    check("ferr_done",     32'(done_cnt - d0), 32'd1);
    check("ferr_flag",     32'(done_err), 32'h1);
    check("ferr_out_kept", 32'(done_out), 32'h5A);
    check("ferr_low_busy", 32'(busy_cycles - b0), 32'd0);
    check("ferr_err_hold", 32'(err), 32'h1);
    rx = 1'b1;
    idle(5);
    send_frame(8'h81, 1'b1, -1, -1, -1);
    idle(4); #2;
    check("ferr_next_out", 32'(out), 32'h81);
    check("ferr_next_err", 32'(err), 32'h0);
    check("ferr_next_cnt", 32'(done_cnt - d0), 32'd2);

    // Abort by en low during bit 3
    d0 = done_cnt;
    send_frame(8'hFF, 1'b1, -1, 72, -1);
    idle(4); #2;
    check("abort_done", 32'(done_cnt - d0), 32'd0);
    check("abort_out",  32'(out), 32'h81);
    check("abort_busy", 32'(busy), 32'h0);

    // Abort by rst_n low mid-frame
    send_frame(8'hFF, 1'b1, -1, -1, 80);
    idle(4); #2;
    check("rst_done", 32'(done_cnt - d0), 32'd0);
    send_frame(8'h42, 1'b1, -1, -1, -1);
    idle(4); #2;
    check("recover_out",  32'(out), 32'h42);
    check("recover_done", 32'(done_cnt - d0), 32'd1);

    // Single-cycle inverted sample at the centre of data bit 2
    send_frame(8'hFF, 1'b1, 56, -1, -1);
    idle(4); #2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    check("vote_out", 32'(out), 32'hFF);
`else
    check("vote_out", 32'(out), 32'hFB);
`endif
    check("vote_err", 32'(err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart8_receiver.md
# uart8_receiver

8-bit UART receiver: recovers one start bit, 8 data bits (LSB first) and one stop bit from the serial rx line, no parity. Runs on an oversampled clock (OVERSAMPLE × baud), produced by the same divider chain that feeds the transmitter's baud clock. Delivers each received byte on a parallel bus with a one-cycle `done` strobe and a framing-error flag. Sits at the far end of the link from the 8-bit transmitter and uses the shared `RESET`/`IDLE`/`START_BIT`/`DATA_BITS`/`STOP_BIT` state encodings from `UartStates.vh`.

## Interface
- `OVERSAMPLE`, default 16: `clk` cycles per bit. Must be even and ≥ 8.
- `clk`  in  1  oversampled baud clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  receiver enable; low forces `RESET` on the next `clk`.
- `in`  in  1  rx line, asynchronous, idle high.
- `busy`  out  1  frame reception in progress.
- `done`  out  1  one-cycle strobe at end of frame.
- `err`  out  1  framing error on the last frame.
- `out`  out  8  last good received byte.

## Operation
- **Input synchronizer.** `in` passes through a 2-flop synchronizer (`in_sync`), reset to 1. All decisions use `in_sync` plus a 3-bit history of its last three values.
- **Bit decision.** Value of the bit at the sample point (see Configuration). `cnt` is the sample counter.
- **`RESET`.**
  - Clears `busy`, `done` and `cnt`.
  - Moves to `IDLE` when `en == 1` and `in_sync == 1`, so a line held low never triggers a start.
- **`IDLE`.** When `in_sync == 0`, clears `cnt` and moves to `START_BIT`.
- **`START_BIT`.**
  - `cnt` increments each cycle.
  - At `cnt == OVERSAMPLE/2 - 1`, takes the bit decision.
  - Decision 1 (glitch): return to `IDLE`, no flag.
  - Decision 0: set `busy = 1`, clear `err`, clear `cnt` and `bit_index`, move to `DATA_BITS`.
- **`DATA_BITS`.**
  - At `cnt == OVERSAMPLE - 1`, shifts the decision into `shift[bit_index]`, clears `cnt` and increments `bit_index`.
  - Moves to `STOP_BIT` after `bit_index == 7`.
- **`STOP_BIT`.** At `cnt == OVERSAMPLE - 1`, takes the decision:
  - Decision 1: `out <= shift`, `err <= 0`, `done <= 1`, `busy <= 0`, next state `IDLE`.
  - Decision 0: `out` is unchanged, `err <= 1`, `done <= 1`, `busy <= 0`, next state `RESET` (waits for the line to return high).
- **`done`** is cleared on every cycle other than the one above.
- **`err`** holds until the next confirmed start bit, or until reset.
- **Undefined state codes** go to `RESET`.

## Timing
- **Reset values** (`rst_n` low): `busy = 0`, `done = 0`, `err = 0`, `out = 8'h00`, `in_sync = 1`, history all ones, state `RESET`.
- **Pin-to-`in_sync` latency**: 2 cycles.
- **Frame timing.** Let T be the first cycle with `in_sync == 0` in `IDLE`.
  - Start decision at T + OVERSAMPLE/2.
  - Data bit k decided at T + OVERSAMPLE/2 + (k+1)·OVERSAMPLE.
  - Stop decision at T + OVERSAMPLE/2 + 9·OVERSAMPLE.
  - `done` is high in the following cycle. For OVERSAMPLE = 16: `done` at T + 153.
- **Back-to-back frames.**
  - One stop bit is sufficient. `IDLE` is re-entered at the stop centre, so the next start edge, OVERSAMPLE/2 cycles later, is caught.
  - The receiver tolerates transmitter mark extension: an extra high stop cycle is just idle.
- **`en` low mid-frame.** Next state is `RESET`; `busy` and `done` clear on the following cycle; `out` and `err` are retained; the partial byte is discarded.
- **`rst_n` low mid-frame.** All outputs return immediately to their reset values; no `done`.
- **Simultaneous events.** `en` low overrides a stop decision in the same cycle: no `done`, `out` unchanged.

## Configuration
- **`UART_RX_MAJORITY_VOTE_EN` defined.** Decision = majority of the 3-bit `in_sync` history at the decision cycle, i.e. samples at the sample point, −1 and −2 cycles. Single-cycle glitches at the bit centre are rejected.
- **Not defined.** Decision = `in_sync` at the decision cycle only. The history register is not instantiated.
- Latency is identical in both builds.

## Test plan
- **Normal frame.** Reset, `en = 1`, OVERSAMPLE = 16, send 0xA5 with 16 clk/bit → `busy` rises at start confirm, `done` one cycle at T + 153, `out = 8'hA5`, `err = 0`.
- **Back-to-back frames.** Send 0x00, 0xFF, 0x3C with one stop bit each → three `done` pulses exactly 160 cycles apart, `out` = 0x00, 0xFF, 0x3C in turn.
- **Start-bit glitch.** Drive `in` low for 4 cycles, then high → no `busy`, no `done`, state back in `IDLE`; a following 0x5A frame is received correctly.
- **Framing error.** Send 0x3C with the stop bit low, line then held low 40 cycles, then high → `done` pulse with `err = 1`, `out` keeps its previous value, no new start while low; the next 0x81 frame gives `err = 0`, `out = 8'h81`.
- **Abort.** Mid-frame (bit 3), `en` low for 1 cycle → no `done`; assert `rst_n` low in another frame → `out = 0`, `busy = 0` immediately. Both recover on the next frame.
- **Majority vote.** Single-cycle inverted pulse on data bit 2 at its centre cycle (frame 0xFF) → with `UART_RX_MAJORITY_VOTE_EN`: `out = 8'hFF`; without: `out = 8'hFB`.
